// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback
//   sources, A (ALU) and B (load unit). Each source pushes {addr,data} into
//   its own FIFO with a valid/ready handshake. At most one FIFO head is
//   popped per cycle, and it becomes a registered write on the wr_* port.
//   Entries addressed to register 0 are popped and dropped, so the port
//   never sees them.
//
// Build option
//   WB_ARB_RR_EN  defined   : round-robin between A and B on ties
//                 undefined : A has priority; after B has lost MAX_WAIT
//                             times in a row, B is forced to win
//
// Ports
//   clk_i                  clock
//   nrst_i                 synchronous reset, active low
//   a_valid_i / a_ready_o  source A handshake; a_addr_i / a_data_i payload
//   b_valid_i / b_ready_o  source B handshake; b_addr_i / b_data_i payload
//   wr_en_o / wr_addr_o / wr_data_o   registered register-file write
//   idle_o                 both FIFOs empty and no write in flight
//
// Grant FSM (fixed-priority build)
//   state   | meaning
//   A_PRI   | A head wins if present, otherwise B head
//   B_FORCE | B head wins unconditionally for one cycle

module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_data_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_data_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          idle_o
);

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  // ---------------- source FIFOs ----------------
  logic [AW-1:0] a_addr_q [FIFO_DEPTH];
  logic [DW-1:0] a_data_q [FIFO_DEPTH];
  logic [AW-1:0] b_addr_q [FIFO_DEPTH];
  logic [DW-1:0] b_data_q [FIFO_DEPTH];
  logic [PW-1:0] a_wp_q, a_rp_q, b_wp_q, b_rp_q;

  logic a_full, b_full, a_ne, b_ne, a_push, b_push;
  logic grant_a, grant_b;

  // Full when the index bits match but the wrap bits differ.
  assign a_full = (a_wp_q[IW] != a_rp_q[IW]) && (a_wp_q[IW-1:0] == a_rp_q[IW-1:0]);
  assign b_full = (b_wp_q[IW] != b_rp_q[IW]) && (b_wp_q[IW-1:0] == b_rp_q[IW-1:0]);
  assign a_ne   = (a_wp_q != a_rp_q);
  assign b_ne   = (b_wp_q != b_rp_q);

  // Ready looks at full only, so a full FIFO refuses even while draining.
  assign a_ready_o = nrst_i & ~a_full;
  assign b_ready_o = nrst_i & ~b_full;
  assign a_push    = a_valid_i & a_ready_o;
  assign b_push    = b_valid_i & b_ready_o;

  always_ff @(posedge clk_i) begin
    if (a_push) begin
      a_addr_q[a_wp_q[IW-1:0]] <= a_addr_i;
      a_data_q[a_wp_q[IW-1:0]] <= a_data_i;
    end
    if (b_push) begin
      b_addr_q[b_wp_q[IW-1:0]] <= b_addr_i;
      b_data_q[b_wp_q[IW-1:0]] <= b_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      a_wp_q <= '0;
      a_rp_q <= '0;
      b_wp_q <= '0;
      b_rp_q <= '0;
    end else begin
      if (a_push)  a_wp_q <= a_wp_q + PW'(1);
      if (grant_a) a_rp_q <= a_rp_q + PW'(1);
      if (b_push)  b_wp_q <= b_wp_q + PW'(1);
      if (grant_b) b_rp_q <= b_rp_q + PW'(1);
    end
  end

  // ---------------- arbitration ----------------
`ifdef WB_ARB_RR_EN
  // last_b_q: B won the most recent tie. Resets to 1 so A takes the first tie.
  logic last_b_q;

  always_ff @(posedge clk_i) begin
    if (!nrst_i)          last_b_q <= 1'b1;
    else if (a_ne && b_ne) last_b_q <= grant_b;
  end

  always_comb begin
    grant_a = a_ne;
    grant_b = b_ne;
    if (a_ne && b_ne) begin
      grant_a = last_b_q;
      grant_b = ~last_b_q;
    end
  end
`else
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {A_PRI = 1'b0, B_FORCE = 1'b1} state_e;
  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q <= A_PRI;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Counting the loss being granted now means B is forced on the cycle
  // right after its MAX_WAIT-th loss, never a cycle later.
  always_comb begin
    wait_d  = '0;
    state_d = A_PRI;
    if (state_q == A_PRI) begin
      if (grant_a && b_ne) wait_d = wait_q + WW'(1);
      if (wait_d == WW'(MAX_WAIT)) state_d = B_FORCE;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      A_PRI: begin
        if (a_ne)      grant_a = 1'b1;
        else if (b_ne) grant_b = 1'b1;
      end
      B_FORCE: grant_b = b_ne;
      default: ;
    endcase
  end
`endif

  // ---------------- write port ----------------
  logic          pop, issue;
  logic [AW-1:0] pop_addr;
  logic [DW-1:0] pop_data;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  assign pop      = grant_a | grant_b;
  assign pop_addr = grant_a ? a_addr_q[a_rp_q[IW-1:0]] : b_addr_q[b_rp_q[IW-1:0]];
  assign pop_data = grant_a ? a_data_q[a_rp_q[IW-1:0]] : b_data_q[b_rp_q[IW-1:0]];
  assign issue    = pop && (pop_addr != '0);

  // Address/data hold their last value on non-write cycles.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= issue;
      if (issue) begin
        wr_addr_q <= pop_addr;
        wr_data_q <= pop_data;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign idle_o    = ~a_ne & ~b_ne & ~wr_en_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        a_valid_i, b_valid_i;
  logic [4:0]  a_addr_i, b_addr_i;
  logic [31:0] a_data_i, b_data_i;
  logic        a_ready_o, b_ready_o, wr_en_o, idle_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4), .AW(5), .DW(32)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] wlog[$];

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ar;
    logic        br;
    logic        idl;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic en, input logic [4:0] wa, input logic [31:0] wd,
                              input logic idl);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.en = en; v.wa = wa; v.wd = wd; v.ar = 1'b1; v.br = 1'b1; v.idl = idl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and log writes.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (wr_en_o === 1'b1) wlog.push_back(wr_addr_o);
  endtask

  task automatic idle_inputs();
    a_valid_i = 1'b0; a_addr_i = '0; a_data_i = '0;
    b_valid_i = 1'b0; b_addr_i = '0; b_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst_i = 1'b0;
    step();
    step();
    nrst_i = 1'b1;
  endtask

  initial begin
    int nfull;
    int nw;
    bit done;

    // Row inputs are applied before an edge; expectations hold after it.
    vecs[0]  = mk(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 32'hDEADBEEF, 1'b1);
    vecs[3]  = mk(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 32'hDEADBEEF, 1'b0);
    vecs[4]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 32'hDEADBEEF, 1'b1);
    vecs[5]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB0B00007, 1'b0, 5'd3, 32'hDEADBEEF, 1'b0);
    vecs[6]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB0B00007, 1'b0);
    vecs[7]  = mk(1'b1, 5'd9, 32'hA9, 1'b1, 5'd10, 32'hB10, 1'b0, 5'd7, 32'hB0B00007, 1'b0);
    vecs[8]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA9, 1'b0);
    vecs[9]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hB10, 1'b0);
    vecs[10] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 32'hB10, 1'b1);
    vecs[11] = mk(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 32'hB10, 1'b0);
    vecs[12] = mk(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h11, 1'b0);
    vecs[13] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22, 1'b0);
    vecs[14] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 32'h22, 1'b1);
    vecs[15] = mk(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b0, 5'd2, 32'h22, 1'b0);
    vecs[16] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 32'h22, 1'b0);
    vecs[17] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 32'h22, 1'b1);

    // Reset held with a_valid high: nothing pushed, nothing written.
    idle_inputs();
    nrst_i = 1'b0;
    a_valid_i = 1'b1; a_addr_i = 5'd3; a_data_i = 32'h55;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_a_ready", {31'b0, a_ready_o}, 32'd0);
      chk("rst_b_ready", {31'b0, b_ready_o}, 32'd0);
      chk("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
    end
    nrst_i = 1'b1;
    a_valid_i = 1'b0;
    #1;
    chk("rel_a_ready", {31'b0, a_ready_o}, 32'd1);
    chk("rel_b_ready", {31'b0, b_ready_o}, 32'd1);
    chk("rel_idle", {31'b0, idle_o}, 32'd1);
    step();
    chk("rel_idle2", {31'b0, idle_o}, 32'd1);
    chk("rel_wr_en", {31'b0, wr_en_o}, 32'd0);
    chk("rel_wr_addr", {27'b0, wr_addr_o}, 32'd0);
    chk("rel_wr_data", wr_data_o, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      a_valid_i = vecs[i].av; a_addr_i = vecs[i].aa; a_data_i = vecs[i].ad;
      b_valid_i = vecs[i].bv; b_addr_i = vecs[i].ba; b_data_i = vecs[i].bd;
      step();
      chk($sformatf("v%0d_wr_en", i), {31'b0, wr_en_o}, {31'b0, vecs[i].en});
      chk($sformatf("v%0d_wr_addr", i), {27'b0, wr_addr_o}, {27'b0, vecs[i].wa});
      chk($sformatf("v%0d_wr_data", i), wr_data_o, vecs[i].wd);
      chk($sformatf("v%0d_a_ready", i), {31'b0, a_ready_o}, {31'b0, vecs[i].ar});
      chk($sformatf("v%0d_b_ready", i), {31'b0, b_ready_o}, {31'b0, vecs[i].br});
      chk($sformatf("v%0d_idle", i), {31'b0, idle_o}, {31'b0, vecs[i].idl});
    end

    // Both sources streaming: A addrs 16..31, B addrs 1..15.
    do_reset();
    wlog.delete();
    for (int c = 0; c < 30; c++) begin
      a_valid_i = 1'b1; a_addr_i = 5'(16 + (c % 16)); a_data_i = c;
      b_valid_i = 1'b1; b_addr_i = 5'(1 + (c % 15));  b_data_i = c;
      step();
    end
    idle_inputs();
    chk("stream_nwrites", wlog.size(), 32'd29);
    nw = wlog.size();
    for (int k = 0; k < nw; k++) begin
`ifdef WB_ARB_RR_EN
      chk($sformatf("stream_src%0d", k), {31'b0, ~wlog[k][4]}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
      chk($sformatf("stream_src%0d", k), {31'b0, ~wlog[k][4]}, (k % 5 == 4) ? 32'd1 : 32'd0);
`endif
    end
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (idle_o === 1'b1) done = 1'b1;
    end
    chk("stream_drain_idle", {31'b0, done}, 32'd1);

    // B fills while A holds the port; B then drains in push order.
    do_reset();
    wlog.delete();
`ifdef WB_ARB_RR_EN
    nfull = 1;
`else
    nfull = 4;
`endif
    a_valid_i = 1'b1; a_addr_i = 5'd16; a_data_i = 32'hA0;
    b_valid_i = 1'b1; b_addr_i = 5'd5;  b_data_i = 32'hB5;
    step();
    a_addr_i = 5'd17; b_addr_i = 5'd6; b_data_i = 32'hB6;
    step();
    chk("bfull_ready1", {31'b0, b_ready_o}, 32'd0);
    b_addr_i = 5'd7; b_data_i = 32'hB7;
    for (int k = 2; k <= nfull; k++) begin
      a_addr_i = 5'(16 + k);
      step();
      chk($sformatf("bfull_ready%0d", k), {31'b0, b_ready_o}, 32'd0);
    end
    a_addr_i = 5'(17 + nfull);
    step();
    chk("bfull_ready_after", {31'b0, b_ready_o}, 32'd1);
    idle_inputs();
    for (int c = 0; c < 20; c++) step();
    chk("bfull_idle", {31'b0, idle_o}, 32'd1);
    begin
      logic [4:0] bseq[$];
      foreach (wlog[k]) if (wlog[k] < 5'd16) bseq.push_back(wlog[k]);
      chk("border_count", bseq.size(), 32'd2);
      if (bseq.size() >= 2) begin
        chk("border_first", {27'b0, bseq[0]}, 32'd5);
        chk("border_second", {27'b0, bseq[1]}, 32'd6);
      end
    end

    // Reset while both FIFOs hold entries and a write is on the port.
    do_reset();
    a_valid_i = 1'b1; a_addr_i = 5'd11; a_data_i = 32'h111;
    b_valid_i = 1'b1; b_addr_i = 5'd12; b_data_i = 32'h112;
    step();
    a_addr_i = 5'd13; a_data_i = 32'h113;
    b_addr_i = 5'd14; b_data_i = 32'h114;
    step();
    chk("mid_wr_en_pre", {31'b0, wr_en_o}, 32'd1);
    chk("mid_wr_addr_pre", {27'b0, wr_addr_o}, 32'd11);
    idle_inputs();
    nrst_i = 1'b0;
    step();
    chk("mid_wr_en", {31'b0, wr_en_o}, 32'd0);
    chk("mid_wr_addr", {27'b0, wr_addr_o}, 32'd0);
    chk("mid_a_ready", {31'b0, a_ready_o}, 32'd0);
    chk("mid_idle", {31'b0, idle_o}, 32'd1);
    nrst_i = 1'b1;
    wlog.delete();
    for (int c = 0; c < 10; c++) step();
    chk("mid_no_writes", wlog.size(), 32'd0);
    chk("mid_idle_after", {31'b0, idle_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
